// File: rtl/mmio_device_router_if.sv
// Bus bundle for mmio_device_router: CPU data port, data-memory port and per-channel device handshakes.
// The router takes the slave modport; the CPU/memory/device side takes master.
interface mmio_device_router_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned N_CH   = 2
);
   logic [ADDR_W-1:0]      cpu_addr;
   logic [DATA_W-1:0]      cpu_wdata;
   logic                   cpu_we;
   logic                   cpu_re;
   logic                   cpu_stall;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic                   mem_we;
   logic                   mem_re;
   logic [N_CH*DATA_W-1:0] dev_data;
   logic [N_CH-1:0]        dev_valid;
   logic [N_CH-1:0]        dev_ready;
   logic [N_CH-1:0]        dev_done;
   logic [N_CH-1:0]        dev_timeout;

   modport master (
      output cpu_addr, cpu_wdata, cpu_we, cpu_re, dev_ready, dev_done,
      input  cpu_stall, mem_addr, mem_wdata, mem_we, mem_re, dev_data, dev_valid, dev_timeout
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we, cpu_re, dev_ready, dev_done,
      output cpu_stall, mem_addr, mem_wdata, mem_we, mem_re, dev_data, dev_valid, dev_timeout
   );
endinterface

// File: rtl/mmio_device_router.sv
// Multi-channel MMIO router: diverts CPU stores at device addresses to per-channel handshakes,
// maintains status words in memory. Optional done-timeout enabled by macro MMIO_TIMEOUT_EN.
module mmio_device_router #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       N_CH        = 2,
   parameter logic [ADDR_W-1:0] DEV_BASE    = 'h0000_0001,
   parameter int unsigned       DEV_STRIDE  = 4,
   parameter logic [ADDR_W-1:0] STAT_BASE   = 'h0000_FFFC,
   parameter int unsigned       TIMEOUT_CYC = 1024
) (
   input logic                 clock,
   input logic                 reset,
   mmio_device_router_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_DONE,
      ST_CLEAR
   } state_t;

   state_t                 r_state     [N_CH];
   state_t                 w_nxt_state [N_CH];
   logic [N_CH*DATA_W-1:0] r_dev_data;

   logic [N_CH-1:0]        w_hit;
   logic [N_CH-1:0]        w_accept;
   logic [N_CH-1:0]        w_clr_req;
   logic [N_CH-1:0]        w_gnt;
   logic [N_CH-1:0]        w_to_fire;
   logic [N_CH-1:0]        w_clr_two;

   function automatic logic [ADDR_W-1:0] f_dev_addr(input int unsigned ch);
      return DEV_BASE + ADDR_W'(DEV_STRIDE) * ADDR_W'(ch);
   endfunction

   function automatic logic [ADDR_W-1:0] f_stat_addr(input int unsigned ch);
      return STAT_BASE - ADDR_W'(4 * ch);
   endfunction

   always_comb begin
      w_hit     = '0;
      w_clr_req = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         w_hit[i]     = (bus.cpu_addr == f_dev_addr(i));
         w_clr_req[i] = (r_state[i] == ST_CLEAR);
      end
   end

   // Isolate the lowest set bit: lowest-index CLEAR channel owns the memory port.
   assign w_gnt = w_clr_req & (~w_clr_req + N_CH'(1));

   always_comb begin
      w_accept = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         w_accept[i] = bus.cpu_we && w_hit[i] && (r_state[i] == ST_IDLE) && (w_gnt == '0);
   end

`ifdef MMIO_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] r_cnt [N_CH];
   logic [N_CH-1:0]  r_timeout;
   logic [N_CH-1:0]  r_clr_two;

   always_comb begin
      w_to_fire = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         w_to_fire[i] = (r_state[i] == ST_WAIT_DONE) && (r_cnt[i] == CNT_W'(TIMEOUT_CYC - 1));
   end

   // Counter is held at zero outside WAIT_DONE, which clears it on entry.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_timeout <= '0;
         r_clr_two <= '0;
         for (int unsigned i = 0; i < N_CH; i++) r_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (r_state[i] == ST_WAIT_DONE) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            else                            r_cnt[i] <= '0;
            if (r_state[i] != ST_CLEAR && w_nxt_state[i] == ST_CLEAR)
               r_clr_two[i] <= (r_state[i] == ST_WAIT_DONE) && !bus.dev_done[i];
            if (w_to_fire[i] && !bus.dev_done[i]) r_timeout[i] <= 1'b1;
         end
      end
   end

   assign w_clr_two       = r_clr_two;
   assign bus.dev_timeout = r_timeout;
`else
   assign w_to_fire       = '0;
   assign w_clr_two       = '0;
   assign bus.dev_timeout = '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_CH; i++) r_state[i] <= ST_IDLE;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) r_state[i] <= w_nxt_state[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_dev_data <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++)
            if (w_accept[i]) r_dev_data[i*DATA_W +: DATA_W] <= bus.cpu_wdata;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         w_nxt_state[i] = r_state[i];
         case (r_state[i])
            ST_IDLE:
               if (w_accept[i]) w_nxt_state[i] = ST_SEND;
            ST_SEND:
               if (bus.dev_ready[i])
                  w_nxt_state[i] = bus.dev_done[i] ? ST_CLEAR : ST_WAIT_DONE;
            ST_WAIT_DONE:
               if (bus.dev_done[i] || w_to_fire[i]) w_nxt_state[i] = ST_CLEAR;
            ST_CLEAR:
               if (w_gnt[i]) w_nxt_state[i] = ST_IDLE;
            default:
               w_nxt_state[i] = ST_IDLE;
         endcase
      end
   end

   assign bus.dev_data = r_dev_data;

   always_comb begin
      bus.dev_valid = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         bus.dev_valid[i] = (r_state[i] == ST_SEND);

      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_we    = bus.cpu_we;
      bus.mem_re    = bus.cpu_re;
      bus.cpu_stall = 1'b0;

      if (w_gnt != '0) begin
         bus.mem_we    = 1'b1;
         bus.mem_re    = 1'b0;
         bus.mem_wdata = '0;
         bus.cpu_stall = bus.cpu_we || bus.cpu_re;
         for (int unsigned i = 0; i < N_CH; i++)
            if (w_gnt[i]) begin
               bus.mem_addr  = f_stat_addr(i);
               bus.mem_wdata = w_clr_two[i] ? DATA_W'(2) : '0;
            end
      end else if (bus.cpu_we && w_hit != '0) begin
         bus.mem_re = 1'b0;
         if (w_accept != '0) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = DATA_W'(1);
            for (int unsigned i = 0; i < N_CH; i++)
               if (w_accept[i]) bus.mem_addr = f_stat_addr(i);
         end else begin
            bus.mem_we    = 1'b0;
            bus.cpu_stall = 1'b1;
         end
      end else if (bus.cpu_re && w_hit != '0) begin
         bus.mem_re = 1'b0;
         bus.mem_we = 1'b0;
      end

      if (reset) begin
         bus.mem_we    = 1'b0;
         bus.mem_re    = 1'b0;
         bus.cpu_stall = 1'b0;
      end
   end

endmodule

// File: tb/tb_mmio_device_router.sv
// Directed bench for mmio_device_router (2 channels, default address map).
// Stimulus changes 1ns after a rising edge; combinational outputs are checked mid-cycle.
module tb_mmio_device_router;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   mmio_device_router_if #(.DATA_W(32), .ADDR_W(32), .N_CH(2)) bus ();

   mmio_device_router #(
      .DATA_W(32), .ADDR_W(32), .N_CH(2), .DEV_BASE(32'h0000_0001), .DEV_STRIDE(4),
      .STAT_BASE(32'h0000_FFFC), .TIMEOUT_CYC(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_bus();
      bus.cpu_addr  = 32'h0;
      bus.cpu_wdata = 32'h0;
      bus.cpu_we    = 1'b0;
      bus.cpu_re    = 1'b0;
      bus.dev_ready = 2'b00;
      bus.dev_done  = 2'b00;
   endtask

   task automatic test_reset();
      idle_bus();
      reset = 1'b1;
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h100; bus.cpu_re = 1'b1;
      tick(); tick(); #4;
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", bus.mem_we); end
      total++; if (bus.mem_re !== 1'b0) begin bad++; $display("FAIL rst_mem_re got=%b want=0", bus.mem_re); end
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", bus.cpu_stall); end
      tick();
      reset = 1'b0;
      idle_bus();
      bus.cpu_re = 1'b1; bus.cpu_addr = 32'h200;
      #4;
      total++; if (bus.dev_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b want=00", bus.dev_valid); end
      total++; if (bus.dev_timeout !== 2'b00) begin bad++; $display("FAIL rst_timeout got=%b want=00", bus.dev_timeout); end
      total++; if (bus.dev_data !== 64'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.dev_data); end
      total++; if ({bus.mem_re, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h200}) begin
         bad++; $display("FAIL rst_pass got=re%b we%b %h want=re1 we0 00000200", bus.mem_re, bus.mem_we, bus.mem_addr);
      end
      tick();
      idle_bus();
   endtask

   task automatic test_store_ch0();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1; bus.cpu_wdata = 32'hCAFE_0001;
      #4;
      total++; if ({bus.mem_we, bus.mem_re, bus.cpu_stall, bus.mem_addr, bus.mem_wdata} !== {3'b100, 32'hFFFC, 32'h1}) begin
         bad++; $display("FAIL st0_status got=we%b re%b st%b %h %h want=we1 re0 st0 0000fffc 00000001",
                         bus.mem_we, bus.mem_re, bus.cpu_stall, bus.mem_addr, bus.mem_wdata);
      end
      tick();
      idle_bus();
      #4;
      total++; if (bus.dev_valid !== 2'b01) begin bad++; $display("FAIL st0_valid got=%b want=01", bus.dev_valid); end
      total++; if (bus.dev_data[31:0] !== 32'hCAFE_0001) begin bad++; $display("FAIL st0_data got=%h want=cafe0001", bus.dev_data[31:0]); end
      tick(); #4;
      total++; if (bus.dev_valid !== 2'b01) begin bad++; $display("FAIL st0_hold got=%b want=01", bus.dev_valid); end
      bus.dev_ready = 2'b01;
      tick();
      bus.dev_ready = 2'b00;
      #4;
      total++; if (bus.dev_valid !== 2'b00) begin bad++; $display("FAIL st0_drop got=%b want=00", bus.dev_valid); end
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL st0_wait_we got=%b want=0", bus.mem_we); end
      bus.dev_done = 2'b01;
      tick();
      bus.dev_done = 2'b00;
      #4;
      total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'hFFFC, 32'h0}) begin
         bad++; $display("FAIL st0_clear got=we%b %h %h want=we1 0000fffc 00000000", bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL st0_clr_stall got=%b want=0", bus.cpu_stall); end
      tick(); #4;
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL st0_after got=%b want=0", bus.mem_we); end
      tick();
   endtask

   task automatic test_passthrough();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h100; bus.cpu_wdata = 32'h1234_5678;
      #4;
      total++; if ({bus.mem_we, bus.mem_re, bus.cpu_stall, bus.mem_addr, bus.mem_wdata} !== {3'b100, 32'h100, 32'h1234_5678}) begin
         bad++; $display("FAIL pass_sw got=we%b re%b st%b %h %h want=we1 re0 st0 00000100 12345678",
                         bus.mem_we, bus.mem_re, bus.cpu_stall, bus.mem_addr, bus.mem_wdata);
      end
      tick();
      idle_bus();
      bus.cpu_re = 1'b1; bus.cpu_addr = 32'h1;
      #4;
      total++; if ({bus.mem_re, bus.mem_we, bus.cpu_stall} !== 3'b000) begin
         bad++; $display("FAIL pass_lw_dev0 got=re%b we%b st%b want=000", bus.mem_re, bus.mem_we, bus.cpu_stall);
      end
      tick();
      bus.cpu_addr = 32'h5;
      #4;
      total++; if ({bus.mem_re, bus.cpu_stall} !== 2'b00) begin
         bad++; $display("FAIL pass_lw_dev1 got=re%b st%b want=00", bus.mem_re, bus.cpu_stall);
      end
      tick();
      bus.cpu_addr = 32'h4;
      #4;
      total++; if ({bus.mem_re, bus.mem_addr} !== {1'b1, 32'h4}) begin
         bad++; $display("FAIL pass_lw_near got=re%b %h want=re1 00000004", bus.mem_re, bus.mem_addr);
      end
      tick();
      idle_bus();
      bus.dev_done = 2'b01;
      tick();
      bus.dev_done = 2'b00;
      #4;
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL idle_done_ignored got=%b want=0", bus.mem_we); end
      tick();
   endtask

   task automatic test_busy_stall();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1; bus.cpu_wdata = 32'hA1;
      tick();
      idle_bus();
      bus.dev_ready = 2'b01;
      tick();
      bus.dev_ready = 2'b00;
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1; bus.cpu_wdata = 32'hB2;
      #4;
      total++; if ({bus.cpu_stall, bus.mem_we} !== 2'b10) begin
         bad++; $display("FAIL busy_stall got=st%b we%b want=st1 we0", bus.cpu_stall, bus.mem_we);
      end
      tick();
      bus.dev_done = 2'b01;
      #4;
      total++; if ({bus.cpu_stall, bus.mem_we} !== 2'b10) begin
         bad++; $display("FAIL busy_stall2 got=st%b we%b want=st1 we0", bus.cpu_stall, bus.mem_we);
      end
      tick();
      bus.dev_done = 2'b00;
      #4;
      total++; if ({bus.cpu_stall, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 32'hFFFC, 32'h0}) begin
         bad++; $display("FAIL busy_clear got=st%b we%b %h %h want=st1 we1 0000fffc 00000000",
                         bus.cpu_stall, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      tick(); #4;
      total++; if ({bus.cpu_stall, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b01, 32'hFFFC, 32'h1}) begin
         bad++; $display("FAIL busy_accept got=st%b we%b %h %h want=st0 we1 0000fffc 00000001",
                         bus.cpu_stall, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      tick();
      idle_bus();
      #4;
      total++; if ({bus.dev_valid, bus.dev_data[31:0]} !== {2'b01, 32'hB2}) begin
         bad++; $display("FAIL busy_data got=%b %h want=01 000000b2", bus.dev_valid, bus.dev_data[31:0]);
      end
      bus.dev_ready = 2'b01;
      tick();
      bus.dev_ready = 2'b00;
      bus.dev_done = 2'b01;
      tick();
      bus.dev_done = 2'b00;
      tick();
   endtask

   task automatic test_dual_clear();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1; bus.cpu_wdata = 32'h11;
      tick();
      bus.cpu_addr = 32'h5; bus.cpu_wdata = 32'h22;
      #4;
      total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'hFFF8, 32'h1}) begin
         bad++; $display("FAIL dual_st1 got=we%b %h %h want=we1 0000fff8 00000001", bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      tick();
      idle_bus();
      #4;
      total++; if ({bus.dev_valid, bus.dev_data} !== {2'b11, 32'h22, 32'h11}) begin
         bad++; $display("FAIL dual_valid got=%b %h want=11 0000002200000011", bus.dev_valid, bus.dev_data);
      end
      bus.dev_ready = 2'b11;
      tick();
      bus.dev_ready = 2'b00;
      bus.dev_done = 2'b11;
      bus.cpu_re = 1'b1; bus.cpu_addr = 32'h300;
      tick();
      bus.dev_done = 2'b00;
      #4;
      total++; if ({bus.cpu_stall, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {3'b110, 32'hFFFC, 32'h0}) begin
         bad++; $display("FAIL dual_clr0 got=st%b we%b re%b %h %h want=st1 we1 re0 0000fffc 00000000",
                         bus.cpu_stall, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
      end
      tick(); #4;
      total++; if ({bus.cpu_stall, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {3'b110, 32'hFFF8, 32'h0}) begin
         bad++; $display("FAIL dual_clr1 got=st%b we%b re%b %h %h want=st1 we1 re0 0000fff8 00000000",
                         bus.cpu_stall, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
      end
      tick(); #4;
      total++; if ({bus.cpu_stall, bus.mem_we, bus.mem_re, bus.mem_addr} !== {3'b001, 32'h300}) begin
         bad++; $display("FAIL dual_lw got=st%b we%b re%b %h want=st0 we0 re1 00000300",
                         bus.cpu_stall, bus.mem_we, bus.mem_re, bus.mem_addr);
      end
      tick();
      idle_bus();
   endtask

   task automatic test_ready_done_same();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h5; bus.cpu_wdata = 32'h33;
      tick();
      idle_bus();
      bus.dev_ready = 2'b10; bus.dev_done = 2'b10;
      tick();
      idle_bus();
      #4;
      total++; if ({bus.dev_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b001, 32'hFFF8, 32'h0}) begin
         bad++; $display("FAIL rd_same got=%b we%b %h %h want=00 we1 0000fff8 00000000",
                         bus.dev_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1; bus.cpu_wdata = 32'h44;
      tick();
      idle_bus();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #4;
      total++; if ({bus.dev_valid, bus.dev_data[31:0], bus.mem_we} !== {2'b00, 32'h0, 1'b0}) begin
         bad++; $display("FAIL rmid_abort got=%b %h we%b want=00 00000000 we0", bus.dev_valid, bus.dev_data[31:0], bus.mem_we);
      end
      tick();
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1; bus.cpu_wdata = 32'h55;
      #4;
      total++; if ({bus.cpu_stall, bus.mem_we, bus.mem_wdata} !== {2'b01, 32'h1}) begin
         bad++; $display("FAIL rmid_idle got=st%b we%b %h want=st0 we1 00000001", bus.cpu_stall, bus.mem_we, bus.mem_wdata);
      end
      tick();
      idle_bus();
   endtask

`ifdef MMIO_TIMEOUT_EN
   task automatic test_timeout();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1; bus.cpu_wdata = 32'h66;
      tick();
      idle_bus();
      bus.dev_ready = 2'b01;
      tick();
      bus.dev_ready = 2'b00;
      for (int k = 0; k < 15; k++) tick();
      #4;
      total++; if ({bus.mem_we, bus.dev_timeout} !== 3'b000) begin
         bad++; $display("FAIL to_early got=we%b %b want=we0 00", bus.mem_we, bus.dev_timeout);
      end
      tick(); #4;
      total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dev_timeout} !== {1'b1, 32'hFFFC, 32'h2, 2'b01}) begin
         bad++; $display("FAIL to_fire got=we%b %h %h %b want=we1 0000fffc 00000002 01",
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dev_timeout);
      end
      tick(); tick(); #4;
      total++; if (bus.dev_timeout !== 2'b01) begin bad++; $display("FAIL to_sticky got=%b want=01", bus.dev_timeout); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #4;
      total++; if (bus.dev_timeout !== 2'b00) begin bad++; $display("FAIL to_reset got=%b want=00", bus.dev_timeout); end
      tick();
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      idle_bus();
      #1;
      test_reset();
      test_store_ch0();
      test_passthrough();
      test_busy_stall();
      test_dual_clear();
      test_ready_done_same();
      test_reset_mid();
`ifdef MMIO_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
